// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the arbitrated N-to-1 multiplexer.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        MODO_PRIORIDAD   = 2'd0,
        MODO_ROUND_ROBIN = 2'd1,
        MODO_MANUAL      = 2'd2,
        MODO_RESERVADO   = 2'd3
    } modo_e;

    // Width of a channel index for n channels (n >= 2).
    function automatic int ancho_sel(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arbitro_rr_n.sv
// Combinational arbiter: fixed priority, round-robin from a pointer, or manual select.
module arbitro_rr_n
    import mux_arb_pkg::*;
#(
    parameter  int N_CANALES = 4,
    localparam int ANCHO_SEL = ancho_sel(N_CANALES)
) (
    input  logic [N_CANALES-1:0] solicitudes,
    input  logic [ANCHO_SEL-1:0] puntero,
    input  modo_e                modo,
    input  logic [ANCHO_SEL-1:0] seleccion,
    output logic [N_CANALES-1:0] concesion,
    output logic [ANCHO_SEL-1:0] indice
);

    int                   suma_s;
    logic [ANCHO_SEL-1:0] candidato_s;

    // Grant selection; loops walk downward so the last hit is the highest-priority one.
    always_comb begin
        concesion   = '0;
        indice      = '0;
        suma_s      = 0;
        candidato_s = '0;
        case (modo)
            MODO_ROUND_ROBIN: begin
                for (int i = N_CANALES - 1; i >= 0; i--) begin
                    suma_s = int'(puntero) + i;
                    if (suma_s >= N_CANALES) begin
                        suma_s = suma_s - N_CANALES;
                    end else begin
                        suma_s = suma_s;
                    end
                    candidato_s = ANCHO_SEL'(suma_s);
                    if (solicitudes[candidato_s]) begin
                        concesion              = '0;
                        concesion[candidato_s] = 1'b1;
                        indice                 = candidato_s;
                    end else begin
                        concesion = concesion;
                    end
                end
            end
            MODO_MANUAL: begin
                // Out-of-range selections never match any channel.
                for (int i = 0; i < N_CANALES; i++) begin
                    if ((seleccion == ANCHO_SEL'(i)) && solicitudes[i]) begin
                        concesion[i] = 1'b1;
                        indice       = ANCHO_SEL'(i);
                    end else begin
                        concesion[i] = concesion[i];
                    end
                end
            end
            default: begin
                for (int i = N_CANALES - 1; i >= 0; i--) begin
                    if (solicitudes[i]) begin
                        concesion    = '0;
                        concesion[i] = 1'b1;
                        indice       = ANCHO_SEL'(i);
                    end else begin
                        concesion = concesion;
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/mux_arbitrado_n_a_1.sv
// Registered N-to-1 multiplexer with valid/ready handshake; the granted channel index
// travels with the output word.
module mux_arbitrado_n_a_1
    import mux_arb_pkg::*;
#(
    parameter  int ANCHO     = 32,
    parameter  int N_CANALES = 4,
    localparam int ANCHO_SEL = ancho_sel(N_CANALES)
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [1:0]                 modo_i,
    input  logic [ANCHO_SEL-1:0]       seleccion_i,
    input  logic [N_CANALES-1:0]       valido_i,
    input  logic [N_CANALES*ANCHO-1:0] datos_i,
    output logic [N_CANALES-1:0]       listo_o,
    output logic                       valido_o,
    output logic [ANCHO-1:0]           datos_o,
    output logic [ANCHO_SEL-1:0]       canal_o,
    input  logic                       listo_i
);

    logic [N_CANALES-1:0] concesion_s;
    logic [ANCHO_SEL-1:0] indice_s;
    logic [ANCHO_SEL-1:0] puntero_r;
    logic                 valido_r;
    logic [ANCHO-1:0]     datos_r;
    logic [ANCHO_SEL-1:0] canal_r;
    logic                 cargar_s;
    logic                 transferencia_s;
    logic [ANCHO-1:0]     dato_sel_s;
    modo_e                modo_s;

    assign modo_s = modo_e'(modo_i);

    arbitro_rr_n #(
        .N_CANALES (N_CANALES)
    ) u_arbitro (
        .solicitudes (valido_i),
        .puntero     (puntero_r),
        .modo        (modo_s),
        .seleccion   (seleccion_i),
        .concesion   (concesion_s),
        .indice      (indice_s)
    );

    // Accept strobes are forced low while reset is asserted.
    assign cargar_s        = !valido_r | listo_i;
    assign listo_o         = concesion_s & {N_CANALES{cargar_s & rst_n_i}};
    assign transferencia_s = |(valido_i & listo_o);

    // One-hot data select driven by the grant.
    always_comb begin
        dato_sel_s = '0;
        for (int k = 0; k < N_CANALES; k++) begin
            if (concesion_s[k]) begin
                dato_sel_s = datos_i[k*ANCHO +: ANCHO];
            end else begin
                dato_sel_s = dato_sel_s;
            end
        end
    end

    // Output word register: load on transfer, empty on consume, hold on stall.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valido_r <= 1'b0;
            datos_r  <= '0;
            canal_r  <= '0;
        end else if (transferencia_s) begin
            valido_r <= 1'b1;
            datos_r  <= dato_sel_s;
            canal_r  <= indice_s;
        end else if (listo_i) begin
            valido_r <= 1'b0;
        end
    end

    // Round-robin pointer advances past the granted channel, only in round-robin mode.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            puntero_r <= '0;
        end else if (transferencia_s && (modo_s == MODO_ROUND_ROBIN)) begin
            if (indice_s == ANCHO_SEL'(N_CANALES - 1)) begin
                puntero_r <= '0;
            end else begin
                puntero_r <= indice_s + ANCHO_SEL'(1);
            end
        end
    end

    assign valido_o = valido_r;
    assign datos_o  = datos_r;
    assign canal_o  = canal_r;

endmodule
